// File: rtl/tinyqv_uart_pkg.sv
// rtl/tinyqv_uart_pkg.sv - shared debug UART types, constants and baud helpers
package tinyqv_uart_pkg;

  // Receiver frame position.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clocks per bit; the instantiating module rejects inexact ratios.
  function automatic int uart_cpb(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Width of a down-counter that must be able to hold CPB-1.
  function automatic int uart_cnt_width(input int cpb);
    return (cpb <= 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_rx_buf.sv
// rtl/uart_rx_buf.sv - receive holding buffer with sticky overrun; DEBUG_UART_RX_FIFO_EN selects a 4-deep FIFO
module uart_rx_buf
  import tinyqv_uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] push_data_i,
  input  logic                      pop_i,
  input  logic                      clear_err_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  output logic                      overrun_o
);

  logic full;
  logic empty;
  logic do_pop;
  logic do_push;
  logic drop;
  logic overrun_q;
  logic overrun_d;

  // A pop frees a slot in the same cycle, so a push into a full buffer
  // alongside a pop is accepted rather than counted as an overrun.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);
  assign drop    = push_i & full & ~do_pop;

`ifdef DEBUG_UART_RX_FIFO_EN
  localparam int DEPTH = 4;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [1:0]                rd_ptr_q;
  logic [1:0]                wr_ptr_q;
  logic [2:0]                count_q;

  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign data_o = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      full_q;

  assign full  = full_q;
  assign empty = ~full_q;

  // Single holding register; a new byte wins over a simultaneous pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (do_push) begin
      data_q <= push_data_i;
      full_q <= 1'b1;
    end else if (do_pop) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = full_q ? data_q : '0;
`endif

  assign valid_o = ~empty;

  // Sticky overrun: a drop in the same cycle as a clear leaves it set.
  always_comb begin
    overrun_d = overrun_q;
    if (clear_err_i) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun_o = overrun_q;

endmodule

// File: rtl/debug_uart_rx.sv
// rtl/debug_uart_rx.sv - debug UART 8N1 receiver; DEBUG_UART_RX_FIFO_EN deepens the receive buffer to 4
module debug_uart_rx
  import tinyqv_uart_pkg::*;
#(
  parameter int CLK_HZ   = 64_000_000,
  parameter int BIT_RATE = 4_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  input  logic       uart_rx_read,
  input  logic       uart_rx_clear_err,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       uart_rx_overrun,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_busy
);

  localparam int CPB = uart_cpb(CLK_HZ, BIT_RATE);
  localparam int CW  = uart_cnt_width(CPB);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);

  if ((CLK_HZ % BIT_RATE) != 0 || CPB < 4) begin : g_bad_baud
    $error("debug_uart_rx: CLK_HZ/BIT_RATE must be an integer >= 4");
  end

  logic                      sync1_q;
  logic                      rxd_s_q;
  logic                      prev_s_q;
  logic                      fall;
  logic                      sample;
  rx_state_t                 state_q;
  rx_state_t                 state_d;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;
  logic [2:0]                bit_idx_q;
  logic [2:0]                bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic                      push;
  logic                      frame_set;
  logic                      frame_err_q;
  logic                      frame_err_d;

  // Two-flop synchroniser plus one delayed copy for edge detection; idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      prev_s_q <= 1'b1;
    end else begin
      sync1_q  <= uart_rxd;
      rxd_s_q  <= sync1_q;
      prev_s_q <= rxd_s_q;
    end
  end

  assign fall   = prev_s_q & ~rxd_s_q;
  assign sample = (state_q != IDLE) && (cnt_q == '0);

  // Frame sequencing: half a bit to mid-start, then one bit per sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = sample ? CNT_FULL : cnt_q - CW'(1);
    end

    case (state_q)
      IDLE: begin
        // Only an edge starts a frame, so a stuck-low line stays quiet.
        if (fall) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (sample) begin
          if (rxd_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d   = {rxd_s_q, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start bit be caught.
        if (sample) begin
          state_d = IDLE;
          if (rxd_s_q) push = 1'b1;
          else         frame_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state, bit timer and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Sticky framing error: a new error in a clear cycle still sets it.
  always_comb begin
    frame_err_d = frame_err_q;
    if (uart_rx_clear_err) frame_err_d = 1'b0;
    if (frame_set)         frame_err_d = 1'b1;
  end

  // Framing error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  uart_rx_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (uart_rx_read),
    .clear_err_i (uart_rx_clear_err),
    .data_o      (uart_rx_data),
    .valid_o     (uart_rx_valid),
    .overrun_o   (uart_rx_overrun)
  );

  assign uart_rx_frame_err = frame_err_q;
  assign uart_rx_busy      = (state_q != IDLE);

endmodule
